// File: rtl/snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module   : snake_body_engine
// Purpose  : Snake segment store, movement, growth and collision logic, plus
//            a registered per-pixel "inside a live segment" flag.
// Revision : 1.0 - initial release
// ============================================================================
module snake_body_engine #(
    parameter int CELL_W   = 10,
    parameter int H_CELLS  = 80,
    parameter int V_CELLS  = 60,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        move_tick,
    input  logic        start,
    input  logic [1:0]  dir_in,
    input  logic        dir_valid,
    input  logic [9:0]  box_x,
    input  logic [9:0]  box_y,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    output logic        snack_r,
    output logic        eat,
    output logic        game_over,
    output logic [4:0]  length
);

    localparam logic [1:0] c_DIR_RIGHT = 2'd0;
    localparam logic [1:0] c_DIR_LEFT  = 2'd1;
    localparam logic [1:0] c_DIR_UP    = 2'd2;
    localparam logic [1:0] c_DIR_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t      r_state;
    logic [6:0]  r_seg_x [MAX_LEN];
    logic [5:0]  r_seg_y [MAX_LEN];
    logic [4:0]  r_len;
    logic [1:0]  r_dir;
    logic [1:0]  r_pend;
    logic        r_snack;
    logic        r_eat;
    logic        r_over;

    logic [1:0]  w_eff_dir;
    logic [7:0]  w_nx;
    logic [6:0]  w_ny;
    logic [9:0]  w_nx_px;
    logic [9:0]  w_ny_px;
    logic        w_wall;
    logic        w_food;
    logic        w_self;
    logic        w_collide;
    logic        w_in_screen;
    logic [MAX_LEN-1:0] w_hit;
    logic [MAX_LEN-1:0] w_pix_hit;

    // A pending reversal is ignored; opposite pairs differ only in bit 0.
    always_comb begin
        w_eff_dir = (r_pend == {r_dir[1], ~r_dir[0]}) ? r_dir : r_pend;
        w_nx      = {1'b0, r_seg_x[0]};
        w_ny      = {1'b0, r_seg_y[0]};
        case (w_eff_dir)
            c_DIR_RIGHT: w_nx = w_nx + 8'd1;
            c_DIR_LEFT:  w_nx = w_nx - 8'd1;
            c_DIR_UP:    w_ny = w_ny - 7'd1;
            c_DIR_DOWN:  w_ny = w_ny + 7'd1;
            default:     w_nx = w_nx;
        endcase
    end

    // The extra top bit turns 0-1 into a negative value rather than a wrap.
    assign w_wall = w_nx[7] | (w_nx >= 8'(H_CELLS)) | w_ny[6] | (w_ny >= 7'(V_CELLS));

    assign w_nx_px = ({3'b000, w_nx[6:0]} << 3) + ({3'b000, w_nx[6:0]} << 1);
    assign w_ny_px = ({4'b0000, w_ny[5:0]} << 3) + ({4'b0000, w_ny[5:0]} << 1);
    assign w_food  = (w_nx_px == box_x) && (w_ny_px == box_y);

    assign w_in_screen = (pixel_xpos < 11'(CELL_W * H_CELLS)) &&
                         (pixel_ypos < 11'(CELL_W * V_CELLS));

    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
            logic [10:0] w_x0;
            logic [10:0] w_y0;
            assign w_x0 = ({4'b0000, r_seg_x[i]} << 3) + ({4'b0000, r_seg_x[i]} << 1);
            assign w_y0 = ({5'b00000, r_seg_y[i]} << 3) + ({5'b00000, r_seg_y[i]} << 1);

            // The tail vacates on a non-eating move, so it only counts when eating.
            assign w_hit[i] = (r_seg_x[i] == w_nx[6:0]) && (r_seg_y[i] == w_ny[5:0]) &&
                              ((int'(r_len) > i + 1) || (w_food && (int'(r_len) > i)));

            assign w_pix_hit[i] = (pixel_xpos >= w_x0) && (pixel_xpos < w_x0 + 11'(CELL_W)) &&
                                  (pixel_ypos >= w_y0) && (pixel_ypos < w_y0 + 11'(CELL_W)) &&
                                  (int'(r_len) > i);
        end
    endgenerate

    assign w_self    = |w_hit;
    assign w_collide = w_wall | w_self;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= 7'(H_CELLS / 2 - i);
                r_seg_y[i] <= 6'(V_CELLS / 2);
            end
            r_len   <= 5'(INIT_LEN);
            r_dir   <= c_DIR_RIGHT;
            r_pend  <= c_DIR_RIGHT;
            r_state <= S_IDLE;
            r_snack <= 1'b0;
            r_eat   <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_snack <= (|w_pix_hit) & w_in_screen;
            r_eat   <= 1'b0;
            if (start) begin
                r_state <= S_RUN;
                r_over  <= 1'b0;
                if (r_state != S_IDLE) begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        r_seg_x[i] <= 7'(H_CELLS / 2 - i);
                        r_seg_y[i] <= 6'(V_CELLS / 2);
                    end
                    r_len  <= 5'(INIT_LEN);
                    r_dir  <= c_DIR_RIGHT;
                    r_pend <= c_DIR_RIGHT;
                end
            end else if ((r_state == S_RUN) && move_tick) begin
                if (w_collide) begin
                    r_state <= S_OVER;
                    r_over  <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    r_seg_x[0] <= w_nx[6:0];
                    r_seg_y[0] <= w_ny[5:0];
                    r_dir      <= w_eff_dir;
                    if (w_food) begin
                        r_eat <= 1'b1;
                        if (r_len != 5'(MAX_LEN)) begin
                            r_len <= r_len + 5'd1;
                        end
                    end
                end
            end
            // Placed last so a request made during a restart cycle is kept.
            if (dir_valid) begin
                r_pend <= dir_in;
            end
        end
    end

    assign snack_r   = r_snack;
    assign eat       = r_eat;
    assign game_over = r_over;
    assign length    = r_len;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_body_engine
// Purpose  : Directed self-checking bench for snake_body_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_body_engine;

    logic        vga_clk;
    logic        sys_rst;
    logic        move_tick;
    logic        start;
    logic [1:0]  dir_in;
    logic        dir_valid;
    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        snack_r;
    logic        eat;
    logic        game_over;
    logic [4:0]  length;

    int n_checks;
    int n_fail;

    snake_body_engine dut (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .move_tick  (move_tick),
        .start      (start),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .box_x      (box_x),
        .box_y      (box_y),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .snack_r    (snack_r),
        .eat        (eat),
        .game_over  (game_over),
        .length     (length)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_move();
        move_tick = 1'b1;
        cyc();
        move_tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_in    = d;
        dir_valid = 1'b1;
        cyc();
        dir_valid = 1'b0;
    endtask

    task automatic probe(input int x, input int y);
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        cyc();
    endtask

    task automatic apply_reset();
        sys_rst   = 1'b1;
        move_tick = 1'b0;
        start     = 1'b0;
        dir_valid = 1'b0;
        dir_in    = 2'd0;
        box_x     = 10'd0;
        box_y     = 10'd0;
        #2;
        sys_rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; move_tick = 1'b0; start = 1'b0; dir_valid = 1'b0;
        dir_in = 2'd0; box_x = 10'd0; box_y = 10'd0;
        pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        #3;
        n_checks++;
        if (length !== 5'd3 || game_over !== 1'b0 || eat !== 1'b0 || snack_r !== 1'b0) begin
            $display("FAIL reset_outputs len=%0d go=%b eat=%b snack=%b required len=3 go=0 eat=0 snack=0",
                     length, game_over, eat, snack_r);
            n_fail++;
        end
        cyc();
        sys_rst = 1'b0;
        probe(405, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL reset_head_px actual=%b required=1", snack_r); n_fail++; end
        probe(425, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL reset_beyond_head_px actual=%b required=0", snack_r); n_fail++; end
        probe(385, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL reset_tail_px actual=%b required=1", snack_r); n_fail++; end
        do_move();
        probe(415, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL idle_move_ignored actual=%b required=0", snack_r); n_fail++; end
    endtask

    task automatic test_move_right();
        apply_reset();
        start = 1'b1; move_tick = 1'b1;
        cyc();
        start = 1'b0; move_tick = 1'b0;
        probe(385, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL start_drops_move actual=%b required=1", snack_r); n_fail++; end
        for (int k = 0; k < 5; k++) begin
            do_move();
            cyc();
        end
        probe(455, 300);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL move5_head_px actual=%b required=1", snack_r); n_fail++; end
        probe(405, 300);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL move5_old_px actual=%b required=0", snack_r); n_fail++; end
        n_checks++;
        if (length !== 5'd3 || game_over !== 1'b0) begin
            $display("FAIL move5_status len=%0d go=%b required len=3 go=0", length, game_over); n_fail++;
        end
    endtask

    task automatic test_eat();
        apply_reset();
        box_x = 10'd410; box_y = 10'd300;
        do_start();
        do_move();
        n_checks++;
        if (eat !== 1'b1) begin $display("FAIL eat_pulse actual=%b required=1", eat); n_fail++; end
        box_x = 10'd0; box_y = 10'd0;
        cyc();
        n_checks++;
        if (eat !== 1'b0) begin $display("FAIL eat_one_cycle actual=%b required=0", eat); n_fail++; end
        n_checks++;
        if (length !== 5'd4) begin $display("FAIL eat_length actual=%0d required=4", length); n_fail++; end
        probe(385, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL eat_tail_kept actual=%b required=1", snack_r); n_fail++; end
        probe(375, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL eat_beyond_tail actual=%b required=0", snack_r); n_fail++; end
        #3;
        sys_rst = 1'b1;
        #1;
        n_checks++;
        if (length !== 5'd3 || snack_r !== 1'b0) begin
            $display("FAIL async_reset len=%0d snack=%b required len=3 snack=0", length, snack_r); n_fail++;
        end
        #2;
        sys_rst = 1'b0;
        cyc();
    endtask

    task automatic test_direction();
        apply_reset();
        do_start();
        set_dir(2'd1);
        do_move();
        probe(415, 305);
        n_checks++;
        if (snack_r !== 1'b1 || game_over !== 1'b0) begin
            $display("FAIL reversal_ignored snack=%b go=%b required snack=1 go=0", snack_r, game_over); n_fail++;
        end
        // New direction on the same cycle as a move applies only from the next move.
        dir_in = 2'd3; dir_valid = 1'b1; move_tick = 1'b1;
        cyc();
        dir_valid = 1'b0; move_tick = 1'b0;
        probe(425, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL same_cycle_dir_old actual=%b required=1", snack_r); n_fail++; end
        do_move();
        probe(425, 315);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL same_cycle_dir_next actual=%b required=1", snack_r); n_fail++; end
    endtask

    task automatic test_wall();
        apply_reset();
        do_start();
        for (int k = 0; k < 39; k++) do_move();
        probe(795, 305);
        n_checks++;
        if (snack_r !== 1'b1 || game_over !== 1'b0) begin
            $display("FAIL wall_edge_head snack=%b go=%b required snack=1 go=0", snack_r, game_over); n_fail++;
        end
        do_move();
        n_checks++;
        if (game_over !== 1'b1 || eat !== 1'b0) begin
            $display("FAIL wall_right_over go=%b eat=%b required go=1 eat=0", game_over, eat); n_fail++;
        end
        do_move();
        do_move();
        probe(775, 305);
        n_checks++;
        if (snack_r !== 1'b1 || length !== 5'd3) begin
            $display("FAIL over_frozen_tail snack=%b len=%0d required snack=1 len=3", snack_r, length); n_fail++;
        end
        probe(765, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL over_frozen_beyond actual=%b required=0", snack_r); n_fail++; end
        do_start();
        n_checks++;
        if (game_over !== 1'b0) begin $display("FAIL restart_clears_over actual=%b required=0", game_over); n_fail++; end
        probe(405, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL restart_image_head actual=%b required=1", snack_r); n_fail++; end
        probe(795, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL restart_image_old actual=%b required=0", snack_r); n_fail++; end
        // Top wall: row 0 minus one must not wrap.
        set_dir(2'd2);
        for (int k = 0; k < 30; k++) do_move();
        probe(405, 5);
        n_checks++;
        if (snack_r !== 1'b1 || game_over !== 1'b0) begin
            $display("FAIL top_row_head snack=%b go=%b required snack=1 go=0", snack_r, game_over); n_fail++;
        end
        do_move();
        n_checks++;
        if (game_over !== 1'b1) begin $display("FAIL wall_top_over actual=%b required=1", game_over); n_fail++; end
    endtask

    task automatic test_self_collision();
        apply_reset();
        box_x = 10'd410; box_y = 10'd300;
        do_start();
        do_move();
        box_x = 10'd420;
        do_move();
        box_x = 10'd0; box_y = 10'd0;
        n_checks++;
        if (length !== 5'd5) begin $display("FAIL grow_to_five actual=%0d required=5", length); n_fail++; end
        set_dir(2'd3); do_move();
        set_dir(2'd1); do_move();
        set_dir(2'd2); do_move();
        n_checks++;
        if (game_over !== 1'b1 || length !== 5'd5) begin
            $display("FAIL self_hit go=%b len=%0d required go=1 len=5", game_over, length); n_fail++;
        end
    endtask

    task automatic test_tail_vacate();
        apply_reset();
        box_x = 10'd410; box_y = 10'd300;
        do_start();
        do_move();
        box_x = 10'd0; box_y = 10'd0;
        set_dir(2'd3); do_move();
        set_dir(2'd1); do_move();
        set_dir(2'd2); do_move();
        n_checks++;
        if (game_over !== 1'b0 || length !== 5'd4) begin
            $display("FAIL tail_vacate go=%b len=%0d required go=0 len=4", game_over, length); n_fail++;
        end
        probe(405, 305);
        n_checks++;
        if (snack_r !== 1'b1) begin $display("FAIL tail_vacate_head actual=%b required=1", snack_r); n_fail++; end
        probe(395, 305);
        n_checks++;
        if (snack_r !== 1'b0) begin $display("FAIL tail_vacate_old_tail actual=%b required=0", snack_r); n_fail++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_move_right();
        test_eat();
        test_direction();
        test_wall();
        test_self_collision();
        test_tail_vacate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
